stream_unpacker: RTL and testbench
==================================

Name: stream_unpacker

Overview:
- Width-down converter on the read side of the command FIFO. It consumes wide words from the FIFO's m_valid/m_ready/m_data port and emits them as RATIO narrow beats on a valid/ready stream towards the narrow-datapath consumer.
- The wide word is held in an internal register, so the FIFO entry is freed on accept.
- A new word is accepted in the same cycle the last narrow beat leaves, so sustained throughput is one narrow beat per clock.

Parameters:
- IN_WIDTH, 32, width of the wide input word.
- OUT_WIDTH, 8, width of one narrow output beat. IN_WIDTH must be an integer multiple of OUT_WIDTH; otherwise elaboration fails.
- RATIO, IN_WIDTH/OUT_WIDTH, number of narrow beats per wide word. Derived; do not override.
- LOG2_RATIO, max($clog2(RATIO),1), width of the beat index.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- s_valid  in  1  wide word valid (from FIFO m_valid).
- s_ready  out  1  unpacker can accept a wide word (to FIFO m_ready).
- s_data  in  IN_WIDTH  wide word.
- s_last  in  1  wide word is the final word of a packet.
- m_valid  out  1  narrow beat valid.
- m_ready  in  1  downstream accepts the narrow beat.
- m_data  out  OUT_WIDTH  narrow beat.
- m_last  out  1  final narrow beat of a packet.

Behaviour:
- Handshakes
  - Input handshake i_hs = s_valid & s_ready.
  - Output handshake o_hs = m_valid & m_ready.
  - Transfer occurs only on the clock edge where the handshake is high.
- State
  - Two states: IDLE (hold register empty) and BUSY (hold register full), encoded by a full flag.
  - Registers: hold_data[IN_WIDTH], hold_last, idx[LOG2_RATIO].
- Reset (rst=0, asynchronous)
  - full=0, idx=0, hold_data=0, hold_last=0, immediately and without waiting for clk.
  - Hence m_valid=0, m_data=0, m_last=0, s_ready=1.
  - Deassertion is released synchronously to clk by the top-level reset synchronizer, not inside this block.
- Outputs
  - m_valid = full.
  - m_data = hold_data[idx*OUT_WIDTH +: OUT_WIDTH]. Slices go out LSB first: beat 0 = bits [OUT_WIDTH-1:0].
  - m_last = full & hold_last & (idx==RATIO-1). Words with s_last=0 never raise m_last.
- s_ready
  - s_ready = ~full | (o_hs & idx==RATIO-1).
  - This is a combinational path m_ready->s_ready and is intentional, for zero-bubble operation.
- Latency: a word accepted at edge N presents beat 0 with m_valid=1 in the cycle after edge N.
- IDLE, on i_hs: load hold_data=s_data, hold_last=s_last, idx=0, full=1.
- BUSY, o_hs with idx<RATIO-1: idx increments; everything else holds.
- BUSY, o_hs with idx==RATIO-1:
  - If i_hs is also high: load the new word, idx=0, full stays 1. No idle cycle.
  - Otherwise: full=0, idx=0.
- BUSY, no o_hs: m_data, m_last and idx hold stable. Required AXI-style stability while m_valid & ~m_ready.
- s_valid low in IDLE: nothing changes; m_valid stays 0.
- Reset mid-word: remaining beats are discarded. The next accepted word restarts at beat 0.
- RATIO==1: the block degenerates to a single registered stage. idx stays 0, and every beat with hold_last=1 carries m_last.
- Beat order: no narrow beat is duplicated, dropped or reordered under any m_ready pattern.

Decomposition:
- No shared package is needed. RATIO and LOG2_RATIO are module-local derived parameters.
- The valid/ready stream convention matches the FIFO's and the team's stream blocks.
- No sub-module: the datapath is one register plus a mux.
- Integration: instantiated directly after fifo (fifo.m_* -> stream_unpacker.s_*). Wide data and last travel together through a WIDTH=IN_WIDTH+1 FIFO.

Test Plan:
1. Hold rst=0 for 3 cycles mid-clock, then release -> m_valid=0 and m_data=0 during reset, even without clock edges; s_ready=1 after release.
2. One word 0xDDCCBBAA, s_last=1, m_ready=1 -> m_data = 0xAA,0xBB,0xCC,0xDD on 4 consecutive cycles starting the cycle after accept; m_last=1 only with 0xDD; s_ready=0 during beats 0-2.
3. Back-to-back words 0x03020100 then 0x07060504 (s_last=0,1), s_valid and m_ready held 1 -> 8 consecutive beats 0x00..0x07 with no bubble; s_ready=1 in the cycle of beat 0x03; m_last only on 0x07.
4. Word 0x44332211 with m_ready pattern 1,0,0,1,0,1,1 -> beats 0x11,0x22,0x33,0x44 in order; m_data stable across every m_ready=0 cycle; s_ready rises only with the 0x44 handshake.
5. Word 0xDDCCBBAA, 2 beats taken, then rst pulsed low between edges -> m_valid drops immediately; next word 0x87654321 emits 0x21 first.
6. Configure IN_WIDTH=OUT_WIDTH=32 (RATIO=1) and stream 3 words with random m_ready -> each word appears once, in order, 1-cycle latency; m_last follows s_last.

Source files
------------

// File: rtl/stream_unpacker.sv
// Width-down converter: takes one wide word from the command FIFO read port
// and emits it as RATIO narrow beats, least significant slice first.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | full=0, hold register empty, s_ready=1, m_valid=0
// BUSY  | full=1, hold register holds a word, beat idx is on m_data
module stream_unpacker #(
  parameter  int IN_WIDTH   = 32,
  parameter  int OUT_WIDTH  = 8,
  localparam int RATIO      = IN_WIDTH / OUT_WIDTH,
  localparam int LOG2_RATIO = ($clog2(RATIO) > 1) ? $clog2(RATIO) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic                 m_last
);

  localparam logic [LOG2_RATIO-1:0] LAST_IDX = LOG2_RATIO'(RATIO - 1);

  // A wide word that does not split into whole beats cannot be unpacked.
  if ((IN_WIDTH % OUT_WIDTH) != 0 || IN_WIDTH < OUT_WIDTH) begin : g_width_check
    $error("stream_unpacker: IN_WIDTH must be an integer multiple of OUT_WIDTH");
  end

  logic                  full;
  logic                  hold_last;
  logic [IN_WIDTH-1:0]   hold_data;
  logic [LOG2_RATIO-1:0] idx;
  logic                  at_last;
  logic                  i_hs;
  logic                  o_hs;

  assign at_last = (idx == LAST_IDX);
  assign o_hs    = full & m_ready;
  // m_ready feeds s_ready combinationally so the next word loads on the
  // same edge the last beat leaves, giving one beat per clock sustained.
  assign s_ready = ~full | (o_hs & at_last);
  assign i_hs    = s_valid & s_ready;
  assign m_valid = full;
  assign m_last  = full & hold_last & at_last;

  // Beat select: slice idx of the held word.
  if (RATIO == 1) begin : g_single
    assign m_data = hold_data[OUT_WIDTH-1:0];
  end else begin : g_multi
    logic [OUT_WIDTH-1:0] beat [RATIO];
    for (genvar i = 0; i < RATIO; i++) begin : g_slice
      assign beat[i] = hold_data[i*OUT_WIDTH +: OUT_WIDTH];
    end
    assign m_data = beat[idx];
  end

  // Hold register and beat index. An input handshake only happens while
  // empty or on the final beat's handshake, so it always restarts at beat 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full      <= 1'b0;
      idx       <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (i_hs) begin
      full      <= 1'b1;
      idx       <= '0;
      hold_data <= s_data;
      hold_last <= s_last;
    end else if (o_hs) begin
      if (at_last) begin
        full <= 1'b0;
        idx  <= '0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_unpacker.sv
// Directed bench for stream_unpacker: a 32->8 instance driven from a
// per-cycle vector table plus hand-written reset sequences, and a 32->32
// instance streamed with random m_ready against a small queue model.
`timescale 1ns/1ns
module tb_stream_unpacker;

  logic        clk;
  logic        rst;

  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [31:0] s_data;
  logic [7:0]  m_data;

  logic        r1_s_valid, r1_s_ready, r1_s_last, r1_m_valid, r1_m_ready, r1_m_last;
  logic [31:0] r1_s_data, r1_m_data;

  int n_pass  = 0;
  int n_total = 0;

  stream_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  stream_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(32)) u_r1 (
    .clk(clk), .rst(rst),
    .s_valid(r1_s_valid), .s_ready(r1_s_ready), .s_data(r1_s_data), .s_last(r1_s_last),
    .m_valid(r1_m_valid), .m_ready(r1_m_ready), .m_data(r1_m_data), .m_last(r1_m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  typedef struct packed {
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        m_ready;
    logic        e_valid;
    logic [7:0]  e_data;
    logic        e_last;
    logic        e_sready;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic sv, input logic [31:0] sd, input logic sl, input logic mr,
                     input logic ev, input logic [7:0] ed, input logic el, input logic es);
    vec_t v;
    v.s_valid = sv; v.s_data = sd; v.s_last = sl; v.m_ready = mr;
    v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_sready = es;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] words [3];
    logic        lasts [3];
    logic [31:0] exp_q [$];
    logic        exp_l [$];
    int          wi;
    int          popped;
    int          cyc;
    logic        expect_valid;

    rst = 1'b0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    r1_s_valid = 1'b0; r1_s_data = '0; r1_s_last = 1'b0; r1_m_ready = 1'b0;

    // Reset held for 3 cycles, checked between edges, released mid-clock.
    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data",  m_data, 0);
    check("rst_m_last",  m_last, 0);
    rst = 1'b1;
    #1;
    check("rst_s_ready", s_ready, 1);

    // One word, free-running consumer.
    add(1, 32'hDDCCBBAA, 1, 1,  0, 8'h00, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'hAA, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hBB, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hCC, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'hDD, 1, 1);
    // Back-to-back words, no bubble between 0x03 and 0x04.
    add(1, 32'h03020100, 0, 1,  0, 8'h00, 0, 1);
    add(1, 32'h07060504, 1, 1,  1, 8'h00, 0, 0);
    add(1, 32'h07060504, 1, 1,  1, 8'h01, 0, 0);
    add(1, 32'h07060504, 1, 1,  1, 8'h02, 0, 0);
    add(1, 32'h07060504, 1, 1,  1, 8'h03, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'h04, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h05, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h06, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h07, 1, 1);
    // Backpressure pattern 1,0,0,1,0,1,1 on a non-final word.
    add(1, 32'h44332211, 0, 1,  0, 8'h00, 0, 1);
    add(0, 32'h0,        0, 1,  1, 8'h11, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'h22, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'h22, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h22, 0, 0);
    add(0, 32'h0,        0, 0,  1, 8'h33, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h33, 0, 0);
    add(0, 32'h0,        0, 1,  1, 8'h44, 0, 1);
    add(0, 32'h0,        0, 1,  0, 8'h00, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      s_valid = vecs[i].s_valid; s_data = vecs[i].s_data;
      s_last  = vecs[i].s_last;  m_ready = vecs[i].m_ready;
      #1;
      check($sformatf("vec%0d_m_valid", i), m_valid, vecs[i].e_valid);
      check($sformatf("vec%0d_s_ready", i), s_ready, vecs[i].e_sready);
      check($sformatf("vec%0d_m_last",  i), m_last,  vecs[i].e_last);
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_m_data", i), m_data, vecs[i].e_data);
    end

    // Reset pulsed between edges after two beats of a word.
    @(negedge clk);
    s_valid = 1; s_data = 32'hDDCCBBAA; s_last = 1; m_ready = 1;
    @(negedge clk);
    s_valid = 0;
    #1 check("r5_beat0", m_data, 8'hAA);
    @(negedge clk);
    #1 check("r5_beat1", m_data, 8'hBB);
    @(negedge clk);
    m_ready = 0;
    #1 check("r5_beat2_held", m_data, 8'hCC);
    rst = 1'b0;
    #1;
    check("r5_async_m_valid", m_valid, 0);
    check("r5_async_m_data",  m_data, 0);
    check("r5_async_s_ready", s_ready, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    s_valid = 1; s_data = 32'h87654321; s_last = 0; m_ready = 1;
    #1 check("r5_idle_m_valid", m_valid, 0);
    @(negedge clk);
    s_valid = 0;
    #1;
    check("r5_restart_valid", m_valid, 1);
    check("r5_restart_beat0", m_data, 8'h21);
    @(negedge clk);
    #1 check("r5_restart_beat1", m_data, 8'h43);
    repeat (2) @(negedge clk);
    m_ready = 0;

    // RATIO=1 instance: three words under random backpressure.
    words[0] = 32'hCAFE0001; lasts[0] = 0;
    words[1] = 32'hBEEF0002; lasts[1] = 1;
    words[2] = 32'h12345678; lasts[2] = 1;
    wi = 0; popped = 0; cyc = 0; expect_valid = 0;
    while (popped < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      r1_m_ready = 1'($urandom_range(0, 1));
      r1_s_valid = (wi < 3);
      r1_s_data  = (wi < 3) ? words[wi] : 32'h0;
      r1_s_last  = (wi < 3) ? lasts[wi] : 1'b0;
      #1;
      if (expect_valid) check("r1_latency", r1_m_valid, 1);
      expect_valid = 0;
      if (r1_m_valid && exp_q.size() > 0) begin
        check("r1_m_data", r1_m_data, exp_q[0]);
        check("r1_m_last", r1_m_last, exp_l[0]);
      end else if (r1_m_valid) begin
        check("r1_unexpected_beat", r1_m_valid, 0);
      end
      if (r1_m_valid && r1_m_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(exp_l.pop_front());
        popped++;
      end
      if (r1_s_valid && r1_s_ready) begin
        exp_q.push_back(words[wi]);
        exp_l.push_back(lasts[wi]);
        wi++;
        expect_valid = 1;
      end
    end
    check("r1_all_words_out", popped, 3);
    r1_s_valid = 0;
    @(negedge clk);
    #1 check("r1_drained", r1_m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
